// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants for the instruction front end.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fsm_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low bits of targets are ignored.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Instruction memory request/response channel between the fetch unit and imem.
interface fetch_prefetch_unit_if;
  import riscv_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO of {pc, instr}; flush wins over push/pop.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // The credit limit upstream guarantees a slot for every response.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !flush_i && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: PC, credit-limited imem requests, prefetch queue, redirect flush.
module fetch_prefetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_prefetch_unit_if.master imem,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [XLEN-1:0]       instrF,
  output logic [XLEN-1:0]       pcF,
  output logic [XLEN-1:0]       pcPlus4F
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fsm_state_t      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count;
  logic [CW:0]     credit_used;
  logic            req_valid;
  logic            req_fire;
  logic            push, pop, flush;
  fetch_entry_t    head, push_entry;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    discard_d     = discard_q;
    push          = 1'b0;
    flush         = 1'b0;
    push_entry    = '{pc: rsp_pc_q, instr: imem.imem_rsp_data};

    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase

    credit_used = {1'b0, count} + {1'b0, outstanding_q};
    req_valid   = (state_q == RUN) && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    req_fire    = req_valid && imem.imem_req_ready;

    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem.imem_rsp_valid);

    if (redirect_valid) begin
      // Everything in flight, minus a response landing now, is wrong-path.
      flush      = 1'b1;
      fetch_pc_d = align_pc(redirect_pc);
      rsp_pc_d   = align_pc(redirect_pc);
      discard_d  = outstanding_q - CW'(imem.imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      if (imem.imem_rsp_valid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CW'(1);
        end else begin
          push     = 1'b1;
          rsp_pc_d = rsp_pc_q + PC_STEP;
        end
      end
    end

    pop = instr_valid && instr_ready && !redirect_valid;
  end

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_req_addr  = fetch_pc_q;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (flush),
    .head_o      (head),
    .count_o     (count)
  );

  assign instr_valid = (count != '0);
  assign instrF      = head.instr;
  assign pcF         = head.pc;
  assign pcPlus4F    = head.pc + PC_STEP;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with an in-order behavioural imem.
module tb_fetch_prefetch_unit;
  import riscv_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instrF, pcF, pcPlus4F;

  fetch_prefetch_unit_if mif();

  fetch_prefetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (mif),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instrF         (instrF),
    .pcF            (pcF),
    .pcPlus4F       (pcPlus4F)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          lat      = 1;
  int          n_pop    = 0;
  logic [31:0] exp_pc;
  logic [31:0] hold_addr;
  logic [31:0] pend_addr [$];
  int          pend_due  [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A3C_9E01;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic tick();
    if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
      mif.imem_rsp_valid = 1'b1;
      mif.imem_rsp_data  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      mif.imem_rsp_valid = 1'b0;
      mif.imem_rsp_data  = '0;
    end
    #1;
    if (mif.imem_req_valid && mif.imem_req_ready) begin
      pend_addr.push_back(mif.imem_req_addr);
      pend_due.push_back(cyc + lat);
    end
    if (instr_valid && instr_ready && !redirect_valid) begin
      chk("pcF", pcF, exp_pc);
      chk("instrF", instrF, mem_word(exp_pc));
      chk("pcPlus4F", pcPlus4F, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      n_pop++;
    end
    if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, {31'b0, mif.imem_req_valid}, 32'd0);
    chk({tag, "_req_addr"}, mif.imem_req_addr, RESET_PC);
    chk({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
    chk({tag, "_instrF"}, instrF, 32'd0);
    chk({tag, "_pcF"}, pcF, 32'd0);
    chk({tag, "_pcPlus4F"}, pcPlus4F, 32'd4);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    mif.imem_req_ready = 1'b1;
    mif.imem_rsp_valid = 1'b0;
    mif.imem_rsp_data  = '0;
    pend_addr.delete();
    pend_due.delete();
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    exp_pc = RESET_PC;
  endtask

  task automatic wait_pops(input string tag, input int target, input int budget);
    int spent;
    spent = 0;
    while (n_pop < target && spent < budget) begin
      tick();
      spent++;
    end
    chk(tag, {31'b0, n_pop >= target}, 32'd1);
  endtask

  initial begin
    do_reset();

    // Boot cycle, then the first request and its instruction.
    instr_ready = 1'b1;
    lat = 1;
    #1; chk("boot_no_req", {31'b0, mif.imem_req_valid}, 32'd0);
    tick();
    #1; chk("first_req_valid", {31'b0, mif.imem_req_valid}, 32'd1);
    chk("first_req_addr", mif.imem_req_addr, RESET_PC);
    tick();
    #1; chk("valid_not_yet", {31'b0, instr_valid}, 32'd0);
    tick();
    #1; chk("first_instr_valid", {31'b0, instr_valid}, 32'd1);
    chk("first_pcF", pcF, RESET_PC);
    for (int i = 0; i < 8; i++) begin
      tick();
      #1; chk("stream_no_gap", {31'b0, instr_valid}, 32'd1);
    end

    // Decode stall: queue fills, credit stops requests.
    instr_ready = 1'b0;
    repeat (10) tick();
    #1; chk("stall_req_blocked", {31'b0, mif.imem_req_valid}, 32'd0);
    chk("stall_head_valid", {31'b0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1; chk("resume_no_gap", {31'b0, instr_valid}, 32'd1);
      tick();
    end

    // Memory not ready: address held.
    mif.imem_req_ready = 1'b0;
    #1; hold_addr = mif.imem_req_addr;
    for (int i = 0; i < 3; i++) begin
      #1; chk("hold_valid", {31'b0, mif.imem_req_valid}, 32'd1);
      chk("hold_addr", mif.imem_req_addr, hold_addr);
      tick();
    end
    mif.imem_req_ready = 1'b1;
    repeat (6) tick();

    // Slower memory, redirect with responses still in flight.
    lat = 2;
    repeat (6) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    #1; chk("redirect_no_req", {31'b0, mif.imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1; chk("redir_flushed", {31'b0, instr_valid}, 32'd0);
    chk("redir_req_valid", {31'b0, mif.imem_req_valid}, 32'd1);
    chk("redir_req_addr", mif.imem_req_addr, 32'h0000_0100);
    wait_pops("redir_timeout", n_pop + 4, 40);

    // Redirect while a response lands in the same cycle.
    lat = 1;
    repeat (6) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    #1; chk("redir_rsp_flushed", {31'b0, instr_valid}, 32'd0);
    wait_pops("redir_rsp_timeout", n_pop + 3, 40);

    // Redirect on a full queue with a pop requested, to the wrap boundary.
    instr_ready = 1'b0;
    repeat (8) tick();
    #1; chk("full_req_blocked", {31'b0, mif.imem_req_valid}, 32'd0);
    chk("full_head_valid", {31'b0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    #1; chk("full_redir_flushed", {31'b0, instr_valid}, 32'd0);
    chk("full_redir_addr", mif.imem_req_addr, 32'hFFFF_FFF8);
    wait_pops("wrap_timeout", n_pop + 1, 20);
    #1; chk("wrap_head_pc", pcF, 32'hFFFF_FFFC);
    chk("wrap_pcPlus4F", pcPlus4F, 32'h0000_0000);
    wait_pops("wrap_more_timeout", n_pop + 4, 20);
    chk("wrap_exp_pc", exp_pc, 32'h0000_000C);

    // Asynchronous reset in the middle of a stream.
    repeat (3) tick();
    #2; rst = 1'b0;
    #1; check_reset_outputs("async_rst");
    do_reset();
    instr_ready = 1'b1;
    wait_pops("restart_timeout", n_pop + 3, 20);
    chk("restart_exp_pc", exp_pc, RESET_PC + 32'd12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
